ahb_slave_mem: RTL

- AHB-Lite completer (slave) for the 8-bit-address / 32-bit-data bus driven by the team's AHB master.
- Accepts SINGLE and INCR/WRAP burst beats into a word-organised, byte-writable local memory.
- Inserts a configurable number of wait states and returns a two-cycle ERROR for illegal accesses.
- Acts as the memory-side endpoint used in the AHB–SPI bridge bring-up benches.

---
 rtl/ahb_slv_pkg.sv | 36 +++
 rtl/ahb_slv_mem_array.sv | 35 +++
 rtl/ahb_slave_mem.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ahb_slv_pkg.sv
// Shared encodings for the AHB-Lite memory completer: bus codes, FSM state
// constants and the byte-lane enable helper.
package ahb_slv_pkg;

  // HTRANS codes
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE codes
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // HRESP codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // Byte-lane enables for a legal access of the given size at the given lane offset.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << lane;
      HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slv_mem_array.sv
// Word-organised local memory: byte-enable synchronous write, asynchronous word read.
// Contents are not reset.
module ahb_slv_mem_array #(
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [5:0]  word_idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0]   mem [MEM_DEPTH];
  logic [AW-1:0] idx;
  logic          unused_idx;

  // Callers only present in-range indices, so the upper bits carry no information.
  assign idx        = word_idx[AW-1:0];
  assign unused_idx = ^word_idx;

  assign rdata = mem[idx];

  // Per-lane write; unselected lanes keep their stored value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite completer fronting a byte-writable word memory, with configurable
// wait states and a two-cycle ERROR response for illegal accesses.
// Optional feature: AHB_SLV_WRITE_PROTECT_EN makes writes to words below RO_WORDS illegal.
import ahb_slv_pkg::*;

module ahb_slave_mem #(
  parameter int unsigned MEM_DEPTH   = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_WORDS    = 4
) (
  input  logic        HCLK,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [7:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [8:0] MAX_BYTE  = 9'(MEM_DEPTH * 4);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q;
  logic [2:0]  size_q;
  logic        write_q;
  logic [5:0]  word_q;
  logic        xfer_active, can_accept, accept, illegal;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        unused_sig;

  // Burst type is informational; word index is kept separately from addr_q.
  assign unused_sig = ^{HBURST, addr_q[7:2], (RO_WORDS == 0)};

  // NONSEQ/SEQ carry a beat; IDLE/BUSY never do.
  always_comb begin
    xfer_active = 1'b0;
    case (HTRANS)
      HTRANS_IDLE, HTRANS_BUSY: xfer_active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: xfer_active = 1'b1;
      default: xfer_active = 1'b0;
    endcase
  end

  // New address phases are only taken in cycles where we drive HREADYOUT high.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = can_accept && HSEL && HREADY && xfer_active;

  // Classify the address phase currently on the bus.
  always_comb begin
    illegal = 1'b0;
    if (HSIZE > HSIZE_WORD) illegal = 1'b1;
    if ((HSIZE == HSIZE_HALF) && HADDR[0]) illegal = 1'b1;
    if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) illegal = 1'b1;
    if ({1'b0, HADDR} >= MAX_BYTE) illegal = 1'b1;
`ifdef AHB_SLV_WRITE_PROTECT_EN
    if (HWRITE && (32'(HADDR[7:2]) < RO_WORDS)) illegal = 1'b1;
`else
`endif
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all complete any prior phase and may take a new one.
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State, counter and registered address-phase control.
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      word_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= HADDR;
        size_q  <= HSIZE;
        write_q <= HWRITE;
        word_q  <= HADDR[7:2];
      end
    end
  end

  // Commit on the edge that ends DATA; reset forces IDLE so aborted writes never land.
  assign mem_we = (state_q == ST_DATA) && write_q;
  assign mem_be = byte_en(size_q, addr_q[1:0]);

  ahb_slv_mem_array #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk     (HCLK),
    .we      (mem_we),
    .be      (mem_be),
    .word_idx(word_q),
    .wdata   (HWDATA),
    .rdata   (mem_rdata)
  );

  // Bus outputs decoded from the registered state.
  always_comb begin
    HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    HRDATA    = 32'd0;
    if (((state_q == ST_WAIT) || (state_q == ST_DATA)) && !write_q) HRDATA = mem_rdata;
  end

endmodule
